// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the batch executor.
package instr_register_pkg;

    localparam int DEPTH     = 32;
    localparam int DIV_ITERS = 32;

    typedef logic [$clog2(DEPTH)-1:0] index_t;
    typedef logic [$clog2(DEPTH):0]   count_t;
    typedef logic signed [31:0]       operand_t;
    typedef logic signed [63:0]       result_t;

    typedef enum logic [2:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE, FETCH, EXEC, OUTPUT, DONE
    } exec_state_t;

endpackage

// File: rtl/instr_divider.sv
// Iterative signed divider: magnitude restoring division, one quotient bit per cycle,
// signs restored on the way out (quotient truncates toward zero, remainder follows a).
module instr_divider
    import instr_register_pkg::*;
(
    input  logic     clk,
    input  logic     reset_en,
    input  logic     start,
    input  operand_t a,
    input  operand_t b,
    output logic     busy,
    output result_t  quotient,
    output result_t  remainder,
    output logic     valid
);

    logic                         busy_q;
    logic [$clog2(DIV_ITERS)-1:0] iter_q;
    logic [31:0]                  rem_q, rem_d;
    logic [31:0]                  quo_q, quo_d;
    logic [31:0]                  dvs_q;
    logic                         q_neg_q, r_neg_q;
    logic [32:0]                  shifted, trial;
    logic [31:0]                  abs_a, abs_b;
    result_t                      quo_mag, rem_mag;

    always_comb begin
        abs_a   = a[31] ? 32'(-a) : 32'(a);
        abs_b   = b[31] ? 32'(-b) : 32'(b);
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, dvs_q};
        rem_d   = shifted[31:0];
        quo_d   = {quo_q[30:0], 1'b0};
        if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
        end
        quo_mag = {32'd0, quo_d};
        rem_mag = {32'd0, rem_d};
    end

    // Results are presented combinationally during the final iteration so the
    // caller can capture them on the same edge that completes the divide.
    assign quotient  = q_neg_q ? -quo_mag : quo_mag;
    assign remainder = r_neg_q ? -rem_mag : rem_mag;
    assign valid     = busy_q && (iter_q == ($clog2(DIV_ITERS))'(DIV_ITERS - 1));
    assign busy      = busy_q;

    always_ff @(posedge clk) begin
        if (reset_en) begin
            busy_q  <= 1'b0;
            iter_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (start && !busy_q) begin
            busy_q  <= 1'b1;
            iter_q  <= '0;
            rem_q   <= '0;
            quo_q   <= abs_a;
            dvs_q   <= abs_b;
            q_neg_q <= a[31] ^ b[31];
            r_neg_q <= a[31];
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            iter_q <= iter_q + 1'b1;
            if (valid) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_executor.sv
// Batch executor: fetches instructions from the register file, computes, and hands results out.
// Optional EXEC_STATS_EN adds a saturating count of accepted results on exec_count.
module instr_executor
    import instr_register_pkg::*;
(
    input  logic         clk,
    input  logic         reset_en,
    input  logic         start,
    input  index_t       first_index,
    input  count_t       count,
    input  instruction_t instruction,
    output index_t       read_index,
    output logic         busy,
    output logic         result_valid,
    input  logic         result_ready,
    output result_t      result,
    output index_t       result_index,
    output logic         div_err,
    output logic         done,
    output logic [15:0]  exec_count
);

    exec_state_t  state_q;
    index_t       read_index_q;
    count_t       remaining_q;
    instruction_t instr_q;
    logic         div_started_q;
    result_t      result_q;
    index_t       result_index_q;
    logic         div_err_q;
    logic         result_valid_q;
    logic         done_q;

    result_t a64, b64, alu_d;
    logic    is_div, div_by_zero, div_start;
    logic    div_busy, div_valid;
    result_t div_quo, div_rem;
    logic    handshake;

    always_comb begin
        a64         = {{32{instr_q.op_a[31]}}, instr_q.op_a};
        b64         = {{32{instr_q.op_b[31]}}, instr_q.op_b};
        is_div      = (instr_q.opc == DIV) || (instr_q.opc == MOD);
        div_by_zero = is_div && (instr_q.op_b == '0);
        alu_d       = '0;
        case (instr_q.opc)
            PASSA:   alu_d = a64;
            PASSB:   alu_d = b64;
            ADD:     alu_d = a64 + b64;
            SUB:     alu_d = a64 - b64;
            MULT:    alu_d = a64 * b64;
            default: alu_d = '0;
        endcase
    end

    assign div_start = (state_q == EXEC) && is_div && !div_by_zero && !div_started_q && !div_busy;
    assign handshake = (state_q == OUTPUT) && result_ready;

    instr_divider u_divider (
        .clk       (clk),
        .reset_en  (reset_en),
        .start     (div_start),
        .a         (instr_q.op_a),
        .b         (instr_q.op_b),
        .busy      (div_busy),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    always_ff @(posedge clk) begin
        if (reset_en) begin
            state_q        <= IDLE;
            read_index_q   <= '0;
            remaining_q    <= '0;
            instr_q        <= '0;
            div_started_q  <= 1'b0;
            result_q       <= '0;
            result_index_q <= '0;
            div_err_q      <= 1'b0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        read_index_q <= first_index;
                        remaining_q  <= count;
                        if (count != '0) begin
                            state_q <= FETCH;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    instr_q       <= instruction;
                    div_started_q <= 1'b0;
                    state_q       <= EXEC;
                end
                // A real divide spends one cycle launching the divider and then
                // waits for its final iteration; everything else finishes here.
                EXEC: begin
                    if (!is_div || div_by_zero) begin
                        result_q       <= alu_d;
                        div_err_q      <= div_by_zero;
                        result_index_q <= read_index_q;
                        result_valid_q <= 1'b1;
                        state_q        <= OUTPUT;
                    end else if (div_start) begin
                        div_started_q <= 1'b1;
                    end else if (div_started_q && div_valid) begin
                        result_q       <= (instr_q.opc == DIV) ? div_quo : div_rem;
                        div_err_q      <= 1'b0;
                        result_index_q <= read_index_q;
                        result_valid_q <= 1'b1;
                        state_q        <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        remaining_q    <= remaining_q - 1'b1;
                        if (remaining_q == count_t'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            read_index_q <= (read_index_q == index_t'(DEPTH - 1)) ? '0
                                                                                  : read_index_q + 1'b1;
                            state_q      <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef EXEC_STATS_EN
    logic [15:0] exec_count_q;

    always_ff @(posedge clk) begin
        if (reset_en) begin
            exec_count_q <= '0;
        end else if (handshake && (exec_count_q != 16'hFFFF)) begin
            exec_count_q <= exec_count_q + 16'd1;
        end
    end

    assign exec_count = exec_count_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
    assign exec_count       = '0;
`endif

    assign read_index   = read_index_q;
    assign busy         = (state_q != IDLE);
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign result_index = result_index_q;
    assign div_err      = div_err_q;
    assign done         = done_q;

endmodule

// File: tb/tb_instr_executor.sv
// Scoreboard bench for instr_executor: directed batches with hand-computed results.
module tb_instr_executor;
    import instr_register_pkg::*;

    typedef struct {
        result_t res;
        index_t  idx;
        logic    err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_en;
    logic         start;
    index_t       first_index;
    count_t       count;
    instruction_t instruction;
    index_t       read_index;
    logic         busy;
    logic         result_valid;
    logic         result_ready;
    result_t      result;
    index_t       result_index;
    logic         div_err;
    logic         done;
    logic [15:0]  exec_count;

    instruction_t mem [DEPTH];
    exp_t         sb [$];
    int           total = 0;
    int           bad = 0;
    int           doneCount = 0;
    logic         stallActive = 1'b0;
    result_t      savedRes;
    index_t       savedIdx;
    logic         savedErr;

    always #5 clk = ~clk;

    assign instruction = mem[read_index];

    instr_executor dut (
        .clk          (clk),
        .reset_en     (reset_en),
        .start        (start),
        .first_index  (first_index),
        .count        (count),
        .instruction  (instruction),
        .read_index   (read_index),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_index (result_index),
        .div_err      (div_err),
        .done         (done),
        .exec_count   (exec_count)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input result_t r, input index_t i, input logic e);
        exp_t x;
        x.res = r;
        x.idx = i;
        x.err = e;
        sb.push_back(x);
    endtask

    // Monitor: pops the scoreboard on every handshake and holds the payload steady through stalls.
    always @(negedge clk) begin
        if (reset_en) begin
            stallActive = 1'b0;
        end else begin
            if (done) doneCount++;
            if (stallActive) begin
                if (!result_valid) begin
                    checkOutput("valid_dropped_in_stall", 0, 1);
                end else begin
                    checkOutput("stall_result", result, savedRes);
                    checkOutput("stall_index", result_index, savedIdx);
                    checkOutput("stall_div_err", div_err, savedErr);
                end
            end
            if (result_valid && result_ready) begin
                stallActive = 1'b0;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("result", result, e.res);
                    checkOutput("result_index", result_index, e.idx);
                    checkOutput("div_err", div_err, e.err);
                end
            end else if (result_valid) begin
                stallActive = 1'b1;
                savedRes    = result;
                savedIdx    = result_index;
                savedErr    = div_err;
            end
        end
    end

    task automatic applyStimulus(input index_t first, input int cnt);
        @(negedge clk);
        start       = 1'b1;
        first_index = first;
        count       = count_t'(cnt);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while (busy && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic runTimed(input index_t slot, input int expLat, input string name);
        int lat;
        lat = -1;
        applyStimulus(slot, 1);
        checkOutput({name, "_fetch_busy"}, busy, 1);
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            @(negedge clk);
            if (result_valid) lat = n;
        end
        checkOutput({name, "_latency"}, lat, expLat);
        waitIdle(50);
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = '{opc: ZERO, op_a: 0, op_b: 0};
        mem[0]  = '{opc: ADD,   op_a: 5,      op_b: -7};
        mem[1]  = '{opc: SUB,   op_a: 3,      op_b: 10};
        mem[2]  = '{opc: MULT,  op_a: -40000, op_b: 70000};
        mem[3]  = '{opc: DIV,   op_a: -17,    op_b: 5};
        mem[4]  = '{opc: MOD,   op_a: -17,    op_b: 5};
        mem[5]  = '{opc: DIV,   op_a: 9,      op_b: 0};
        mem[6]  = '{opc: PASSB, op_a: 0,      op_b: -99};
        mem[7]  = '{opc: MOD,   op_a: 17,     op_b: -5};
        mem[8]  = '{opc: DIV,   op_a: 100,    op_b: -7};
        mem[9]  = '{opc: ZERO,  op_a: 5,      op_b: 5};
        mem[31] = '{opc: PASSA, op_a: 123,    op_b: 0};

        reset_en     = 1'b1;
        start        = 1'b0;
        first_index  = '0;
        count        = '0;
        result_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_read_index", read_index, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_result_valid", result_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_result_index", result_index, 0);
        checkOutput("rst_div_err", div_err, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_exec_count", exec_count, 0);
        reset_en = 1'b0;

        $display("[TB] basic batch with stall");
        pushExp(-64'sd2, 0, 1'b0);
        pushExp(-64'sd7, 1, 1'b0);
        pushExp(-64'sd2800000000, 2, 1'b0);
        doneCount    = 0;
        result_ready = 1'b0;
        applyStimulus(0, 3);
        n = 0;
        while (!result_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first_valid_seen", result_valid, 1);
        repeat (5) @(posedge clk);
        #1 result_ready = 1'b1;
        waitIdle(200);
        checkOutput("batch1_done_pulses", doneCount, 1);
`ifdef EXEC_STATS_EN
        checkOutput("batch1_exec_count", exec_count, 3);
`else
        checkOutput("batch1_exec_count", exec_count, 0);
`endif

        $display("[TB] reset mid-divide");
        doneCount = 0;
        applyStimulus(3, 1);
        repeat (10) @(negedge clk);
        reset_en = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_valid", result_valid, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_exec_count", exec_count, 0);
        reset_en = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("mid_rst_no_done", doneCount, 0);
        checkOutput("mid_rst_still_idle", busy, 0);

        $display("[TB] division timing");
        pushExp(-64'sd3, 3, 1'b0);
        runTimed(3, 34, "div_neg");
        pushExp(-64'sd2, 4, 1'b0);
        runTimed(4, 34, "mod_neg");
        pushExp(64'sd0, 5, 1'b1);
        runTimed(5, 2, "div_zero");

        $display("[TB] mixed batch");
        pushExp(-64'sd99, 6, 1'b0);
        pushExp(64'sd2, 7, 1'b0);
        pushExp(-64'sd14, 8, 1'b0);
        pushExp(64'sd0, 9, 1'b0);
        applyStimulus(6, 4);
        waitIdle(300);

        $display("[TB] index wrap with ignored start");
        doneCount = 0;
        pushExp(64'sd123, 31, 1'b0);
        pushExp(-64'sd2, 0, 1'b0);
        applyStimulus(index_t'(DEPTH - 1), 2);
        start       = 1'b1;
        first_index = 10;
        count       = 4;
        @(negedge clk);
        start = 1'b0;
        waitIdle(100);
        checkOutput("wrap_done_pulses", doneCount, 1);
        checkOutput("wrap_queue_drained", sb.size(), 0);

        $display("[TB] zero count");
        doneCount = 0;
        applyStimulus(5, 0);
        checkOutput("zero_done_pulse", done, 1);
        checkOutput("zero_no_valid", result_valid, 0);
        @(negedge clk);
        checkOutput("zero_done_low", done, 0);
        checkOutput("zero_idle", busy, 0);
        checkOutput("zero_done_count", doneCount, 1);

        checkOutput("scoreboard_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instr_executor.md
INSTR_EXECUTOR -- requirements
Module: instr_executor

Interface
REQ-001 Parameters: none; DEPTH, index_t, operand_t, opcode_t and instruction_t SHALL come from instr_register_pkg.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_en  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to run a batch; sampled only in IDLE.
REQ-005 first_index  input  index_t  slot of the first instruction in the batch.
REQ-006 count  input  count_t  number of instructions to execute (0..DEPTH).
REQ-007 instruction  input  instruction_t  combinational read data from the instruction register at read_index.
REQ-008 read_index  output  index_t  registered read address to the instruction register.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 result_valid  output  1  result payload is valid.
REQ-011 result_ready  input  1  consumer accepts the payload.
REQ-012 result  output  result_t (64, signed)  computed value.
REQ-013 result_index  output  index_t  slot that produced the result.
REQ-014 div_err  output  1  the current result came from DIV or MOD with op_b == 0.
REQ-015 done  output  1  one-cycle pulse when the batch completes.
REQ-016 exec_count  output  16  count of executed instructions (see Configuration).

Function
REQ-017 The FSM states SHALL be IDLE, FETCH, EXEC, OUTPUT and DONE.
REQ-018 IDLE transitions: start with count != 0 -> FETCH; start with count == 0 -> DONE; no start -> stay.
- On accept: latch read_index = first_index and remaining = count.
REQ-019 FETCH SHALL last 1 cycle and latch instruction into instr_q at the end of the cycle -> EXEC.
REQ-020 EXEC for ZERO, PASSA, PASSB, ADD, SUB, MULT SHALL take 1 cycle -> OUTPUT.
REQ-021 EXEC for DIV/MOD with op_b != 0 SHALL take exactly 33 cycles (1 load + 32 iterations) -> OUTPUT.
REQ-022 EXEC for DIV/MOD with op_b == 0 SHALL take 1 cycle: result = 0, div_err = 1, divider not started.
REQ-023 Arithmetic: operands are sign-extended to 64 bits.
- ZERO: 0. PASSA: a. PASSB: b.
- ADD: a+b. SUB: a-b. MULT: full signed 64-bit a*b.
- DIV: truncates toward zero. MOD: remainder takes the sign of a.
REQ-024 OUTPUT: result_valid = 1, with result, result_index and div_err held stable until the cycle result_ready = 1.
REQ-025 On the handshake: decrement remaining; if remaining becomes 0 -> DONE, else read_index + 1 (wraps DEPTH-1 -> 0) -> FETCH.
REQ-026 DONE SHALL assert done for exactly 1 cycle -> IDLE.
REQ-027 start while busy SHALL be ignored and SHALL have no effect on the running batch.
REQ-028 result_valid SHALL never deassert without a handshake, except on reset.

Reset
REQ-029 While reset_en is high at a clock edge, the block SHALL enter IDLE.
- Outputs cleared: read_index = 0, busy = 0, result_valid = 0, result = 0, result_index = 0, div_err = 0, done = 0, exec_count = 0.
REQ-030 Reset mid-batch (including mid-divide or while stalled in OUTPUT) SHALL abort the batch with no done pulse; the divider state is discarded.

Configuration
REQ-031 With EXEC_STATS_EN defined, exec_count SHALL increment by 1 on each result handshake, saturate at 16'hFFFF, and clear only on reset.
REQ-032 Without EXEC_STATS_EN, exec_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
REQ-033 count_t (width $clog2(DEPTH)+1) and result_t (signed 64) SHALL be added to instr_register_pkg, alongside the existing opcode_t, operand_t, index_t and instruction_t.
REQ-034 The iterative signed divider SHALL be a sub-module, instr_divider.
- Ports: start, a, b, busy, quotient, remainder, valid.
- Magnitude restoring division with sign fix-up.

Verification
REQ-035 Reset state: reset_en high for 2 cycles -> all outputs 0, busy = 0.
REQ-036 Basic batch with stall: slots 0-2 = ADD(5,-7), SUB(3,10), MULT(-40000,70000); start, first_index = 0, count = 3, result_ready high except held low 5 cycles on the first result.
- Results in order: -2 (idx 0), -7 (idx 1), -2800000000 (idx 2), payload stable during the stall.
- done pulses once; exec_count = 3 when EXEC_STATS_EN is defined.
REQ-037 Division: DIV(-17,5) -> -3; MOD(-17,5) -> -2.
- Each result_valid rises exactly 34 cycles after the FETCH cycle (33 EXEC + 1).
- DIV(9,0) -> result 0, div_err = 1, after 1 EXEC cycle.
REQ-038 Index wrap and zero count: first_index = DEPTH-1, count = 2 -> result_index DEPTH-1 then 0.
- count = 0 -> done pulse 1 cycle after start, no result_valid.
REQ-039 Reset mid-divide: reset_en high 10 cycles into a DIV -> next cycle IDLE, no result, no done.
- A new batch afterwards executes correctly.
- start asserted during a batch has no effect.
